// File: rtl/rca_result_buffer_pkg.sv
// Shared constants for the adder result buffer: default sizing and the
// width of the saturating drop counter.
package rca_result_buffer_pkg;

    localparam int NBITS_DEFAULT   = 16;
    localparam int DEPTH_DEFAULT   = 4;
    localparam int LATENCY_DEFAULT = 1;
    localparam int DROP_W          = 8;

endpackage

// File: rtl/rca_result_fifo.sv
// Result FIFO: power-of-two storage with wrapping pointers and an entry count.
// Storage is deliberately not reset; only pointers and level are.
module rca_result_fifo
    import rca_result_buffer_pkg::*;
#(
    parameter  int W     = NBITS_DEFAULT,
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

    // Credit accounting upstream must make this unreachable.
    full_push_a: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(push && level == LW'(DEPTH)));

endmodule

// File: rtl/rca_result_buffer.sv
// Captures sums from a pipelined adder into a result FIFO, issuing operand
// credit only when every in-flight result is guaranteed a FIFO slot.
module rca_result_buffer
    import rca_result_buffer_pkg::*;
#(
    parameter  int NBITS   = NBITS_DEFAULT,
    parameter  int DEPTH   = DEPTH_DEFAULT,
    parameter  int LATENCY = LATENCY_DEFAULT,
    localparam int LW      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [NBITS-1:0]  sum_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NBITS-1:0]  out_data,
    output logic [DROP_W-1:0] drop_cnt,
    output logic [LW-1:0]     level
);

    // Handshakes: a transfer happens at a rising edge where valid and ready are
    // both 1. op_ready depends only on registered state; out_data is held
    // stable while out_valid=1 and out_ready=0.
    logic [LATENCY-1:0] valid_pipe;
    logic [31:0]        inflight;
    logic               accept;
    logic               push;
    logic               pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) inflight = inflight + 32'(valid_pipe[i]);
    end

    assign op_ready  = (32'(level) + inflight) < 32'(DEPTH);
    assign accept    = op_valid & op_ready;
    assign push      = valid_pipe[LATENCY-1];
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_pipe <= '0;
            drop_cnt   <= '0;
        end else begin
            valid_pipe[0] <= accept;
            for (int i = 1; i < LATENCY; i++) valid_pipe[i] <= valid_pipe[i-1];
            if (op_valid && !op_ready && drop_cnt != '1)
                drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

    rca_result_fifo #(
        .W     (NBITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (sum_in),
        .pop       (pop),
        .head_data (out_data),
        .level     (level)
    );

endmodule

// File: tb/tb_rca_result_buffer.sv
// Directed bench for rca_result_buffer with a behavioural one-stage adder
// feeding sum_in and an in-order scoreboard on the output side.
module tb_rca_result_buffer;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] sum_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  drop_cnt;
    logic [2:0]  level;

    logic [15:0] a;
    logic [15:0] b;
    logic        cin;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    rca_result_buffer #(.NBITS(16), .DEPTH(4), .LATENCY(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .sum_in    (sum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt),
        .level     (level)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // upstream adder: operands sampled on an edge, sum valid one edge later
    always @(posedge clk) begin
        if (op_valid) sum_in <= a + b + 16'(cin);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // scoreboard: accepted issues queue their sum, pops must match in order
    always @(posedge clk) begin
        if (rst_n) begin
            if (op_valid && op_ready) exp_q.push_back(a + b + 16'(cin));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("sb_unexpected_pop", 32'(out_data), 32'hffff_ffff);
                else                   check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] av, input logic [15:0] bv);
        a        = av;
        b        = bv;
        cin      = 1'b0;
        op_valid = 1'b1;
    endtask

    logic [15:0] bp_exp [4];

    initial begin
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        bp_exp    = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_op_ready", 32'(op_ready), 1);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        rst_n = 1'b1;
        step();

        // single op: 0x1234 + 0x0FF0 = 0x2224, visible two edges after issue
        issue(16'h1234, 16'h0ff0);
        step();
        op_valid = 1'b0;
        check("single_early", 32'(out_valid), 0);
        step();
        check("single_valid", 32'(out_valid), 1);
        check("single_data", 32'(out_data), 32'h2224);
        check("single_level", 32'(level), 1);
        out_ready = 1'b1;
        step();
        check("single_drained", 32'(level), 0);

        // back-to-back k+k, one result per cycle
        for (int k = 1; k <= 8; k++) begin
            issue(16'(k), 16'(k));
            check("b2b_op_ready", 32'(op_ready), 1);
            step();
            if (k >= 2) begin
                check("b2b_valid", 32'(out_valid), 1);
                check("b2b_data", 32'(out_data), 32'(2 * (k - 1)));
            end
        end
        op_valid = 1'b0;
        step();
        check("b2b_last", 32'(out_data), 32'd16);
        step();
        check("b2b_empty", 32'(out_valid), 0);

        // backpressure: four accepted, four dropped
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue(16'(16'h0100 * (i + 1)), 16'(i + 1));
            check("bp_op_ready", 32'(op_ready), (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        op_valid = 1'b0;
        step();
        check("bp_level", 32'(level), 4);
        check("bp_drop_cnt", 32'(drop_cnt), 4);
        check("bp_op_ready_full", 32'(op_ready), 0);
        check("bp_head0", 32'(out_data), 32'(bp_exp[0]));
        out_ready = 1'b1;
        for (int j = 1; j < 4; j++) begin
            step();
            check("bp_drain", 32'(out_data), 32'(bp_exp[j]));
        end
        step();
        check("bp_drained", 32'(level), 0);

        // saturation: fill, then 300 refused issues
        out_ready = 1'b0;
        for (int i = 0; i < 304; i++) begin
            issue(16'(i), 16'h0001);
            step();
        end
        op_valid = 1'b0;
        check("sat_drop_cnt", 32'(drop_cnt), 255);
        check("sat_level", 32'(level), 4);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("sat_drained", 32'(level), 0);

        // simultaneous push and pop at level 2
        out_ready = 1'b0;
        issue(16'h0010, 16'h0001);
        step();
        issue(16'h0020, 16'h0002);
        step();
        op_valid = 1'b0;
        step();
        check("pp_level_before", 32'(level), 2);
        check("pp_head_before", 32'(out_data), 32'h0011);
        issue(16'h0030, 16'h0003);
        step();
        op_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("pp_level_same", 32'(level), 2);
        check("pp_head_after", 32'(out_data), 32'h0022);
        out_ready = 1'b0;
        step();
        check("pp_head_hold", 32'(out_data), 32'h0022);
        out_ready = 1'b1;
        step();
        check("pp_head_last", 32'(out_data), 32'h0033);
        step();
        check("pp_drained", 32'(level), 0);

        // reset mid-stream with level=3 and one result in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(16'h0a00, 16'(i));
            step();
        end
        op_valid = 1'b0;
        check("mid_level3", 32'(level), 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_op_ready", 32'(op_ready), 1);
        check("mid_rst_drop", 32'(drop_cnt), 0);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        step();
        check("mid_no_stale_push", 32'(level), 0);
        check("mid_no_stale_valid", 32'(out_valid), 0);

        // recovery after reset
        issue(16'h7000, 16'h0abc);
        step();
        op_valid = 1'b0;
        step();
        check("post_rst_data", 32'(out_data), 32'h7abc);
        out_ready = 1'b1;
        step();
        step();
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rca_result_buffer.md
RCA_RESULT_BUFFER -- requirements
Module: rca_result_buffer

Interface
REQ-001 Parameter NBITS, default 16: width of the sum word, equal to the Nbits of the upstream two-stage pipelined adder.
REQ-002 Parameter DEPTH, default 4: number of result FIFO entries, a power of two, at least 2.
REQ-003 Parameter LATENCY, default 1: cycles from the operand-sampling edge to the edge where the adder sum is valid.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 op_valid  in  1  the source presents an operand pair to the adder this cycle.
REQ-007 op_ready  out  1  the buffer can accept an operand issue this cycle.
REQ-008 sum_in  in  NBITS  combinational sum output of the adder.
REQ-009 out_valid  out  1  the FIFO head holds a result.
REQ-010 out_ready  in  1  the consumer accepts the head this cycle.
REQ-011 out_data  out  NBITS  the FIFO head result.
REQ-012 drop_cnt  out  8  saturating count of operand issues made while op_ready=0.
REQ-013 level  out  clog2(DEPTH)+1  number of FIFO entries currently held.

Function
REQ-014 An issue is op_valid=1 sampled at a rising edge; an accepted issue is an issue with op_ready=1 in the same cycle.
REQ-015 A LATENCY-deep valid shift register shall track accepted issues; its last stage marks the cycle in which sum_in belongs to that issue.
REQ-016 When the last stage is 1, sum_in shall be written to the FIFO tail at that edge; this is the only push source.
REQ-017 A pop shall occur at an edge where out_valid=1 and out_ready=1.
REQ-018 op_ready shall equal (level + number of set valid-stage bits) < DEPTH, be driven only from registers, and not depend on out_ready.
REQ-019 A push and a pop at the same edge shall leave level unchanged and must both take effect.
REQ-020 An issue with op_ready=0 shall not enter the valid pipeline, and drop_cnt shall increment, holding at 255.
REQ-021 out_valid shall be (level != 0); out_data shall be the head entry and shall hold stable while out_valid=1 and out_ready=0.
REQ-022 Read and write pointers shall wrap modulo DEPTH; results shall leave in issue order.
REQ-023 Throughput: one result per cycle sustained when out_ready is held at 1; latency from an accepted issue to out_valid is LATENCY+1 edges when the FIFO is empty.
REQ-024 Because credit covers in-flight results, a push to a full FIFO shall be impossible; an assertion shall flag it.

Reset
REQ-025 Asserting rst_n low shall immediately clear the valid pipeline, the pointers, level and drop_cnt, giving out_valid=0 and op_ready=1.
REQ-026 Results in flight or buffered when reset asserts mid-operation shall be discarded, with no push on the first edge after release.
REQ-027 FIFO storage shall not be reset; out_data is don't-care while out_valid=0.

Structure
REQ-028 The shared package shall hold the default NBITS, DEPTH and LATENCY constants and the drop-counter width of 8.
REQ-029 The FIFO storage with its pointers and level shall be a single sub-module named rca_result_fifo; the credit logic, valid pipeline and drop counter shall live in the top module.

Verification
REQ-030 Single op: issue a=0x1234, b=0x0FF0, cin=0 through the adder -> out_valid rises 2 edges later with out_data=0x2224, level=1.
REQ-031 Back-to-back: 8 issues of a=k, b=k for k=1..8 with out_ready=1 -> outputs 2,4,...,16 in order on consecutive cycles, and op_ready never drops.
REQ-032 Backpressure: out_ready=0 and issue each cycle -> op_ready=0 after 4 accepted issues, level settles at 4, and drop_cnt counts each further issue; release out_ready -> 4 results drain in order.
REQ-033 Saturation: 300 issues while op_ready=0 -> drop_cnt=255.
REQ-034 Simultaneous push and pop with level=2 -> level stays 2 and the data order is preserved.
REQ-035 Reset mid-stream: assert rst_n low with level=3 and one result in flight -> out_valid=0, level=0, op_ready=1 immediately, and no stale push after release.
